// File: rtl/psum_ofifo_pkg.sv
// Shared constants and types for the psum output FIFO bank.
// Sized for the default 8-column, 16-bit, 16-deep configuration.
package psum_ofifo_pkg;

  localparam int COL         = 8;
  localparam int PSUM_BW     = 16;
  localparam int OFIFO_DEPTH = 16;
  localparam int OFIFO_PTR_W = $clog2(OFIFO_DEPTH) + 1;

  // One popped row: lane i holds column i's partial sum.
  typedef logic [COL-1:0][PSUM_BW-1:0] psum_row_t;

endpackage

// File: rtl/psum_fifo_col.sv
// Single-lane synchronous FIFO for one MAC column.
// Pointers carry an extra wrap bit to tell full from empty.
module psum_fifo_col #(
  parameter int psum_bw = 16,
  parameter int depth   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [psum_bw-1:0] din,
  output logic               full,
  output logic               empty,
  output logic [psum_bw-1:0] head
);

  localparam int AW = $clog2(depth);

  logic [AW:0]        wptr;
  logic [AW:0]        rptr;
  logic [psum_bw-1:0] mem [depth];
  logic               push_ok;
  logic               pop_ok;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  // Fullness is judged on pre-edge pointers, so a push into a full lane is
  // dropped even when a pop frees a slot at the same edge.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately left out of reset; the pointers alone define
  // what is valid, and an unreset array maps cleanly onto RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/psum_ofifo.sv
// Output FIFO bank behind the MAC array: per-column capture, lockstep row pop.
// Define PSUM_OFIFO_ERR_EN to add the sticky per-column o_err overflow port.
module psum_ofifo
  import psum_ofifo_pkg::*;
#(
  parameter int col     = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = OFIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col-1:0]         wr,
  input  logic [col*psum_bw-1:0] in,
  input  logic                   rd,
  output logic [col*psum_bw-1:0] out,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   o_valid
`ifdef PSUM_OFIFO_ERR_EN
  ,
  output logic [col-1:0]         o_err
`endif
);

  logic [col-1:0]              full_vec;
  logic [col-1:0]              empty_vec;
  logic [col-1:0][psum_bw-1:0] heads;
  logic                        pop_en;

  // A row leaves only when every lane has data; otherwise rd is ignored.
  assign pop_en  = rd && o_valid;
  assign o_valid = &(~empty_vec);
  assign o_full  = |full_vec;
  assign o_ready = ~o_full;

  for (genvar i = 0; i < col; i++) begin : g_col
    psum_fifo_col #(
      .psum_bw (psum_bw),
      .depth   (depth)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (wr[i]),
      .pop   (pop_en),
      .din   (in[i*psum_bw +: psum_bw]),
      .full  (full_vec[i]),
      .empty (empty_vec[i]),
      .head  (heads[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) out <= '0;
    else if (pop_en) out <= heads;
  end

`ifdef PSUM_OFIFO_ERR_EN
  always_ff @(posedge clk) begin
    if (!reset) o_err <= '0;
    else o_err <= o_err | (wr & full_vec);
  end
`endif

endmodule

// File: doc/psum_ofifo.md
Name: psum_ofifo

Overview:
- Output FIFO bank directly downstream of the MAC array inside the corelet.
- One independent FIFO per column captures partial sums as each column's valid fires. Columns fire skewed in time.
- A full row (all columns) is popped in lockstep toward the SFP/PMEM path.
- Full and ready flags feed the corelet controller so it can stall the array.

Parameters:
col, 8, number of MAC array columns (= FIFO lanes)
psum_bw, 16, partial-sum width per column
depth, 16, entries per column FIFO; power of 2, >= 2

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-low reset
wr  input  col  per-column push strobe; bit i = column i valid from the array
in  input  col*psum_bw  column psums; lane i = in[(i+1)*psum_bw-1 : i*psum_bw]
rd  input  1  pop one full row from all columns
out  output  col*psum_bw  registered popped row; same lane packing as in
o_full  output  1  at least one column FIFO is full
o_ready  output  1  no column FIFO is full (safe to issue array work)
o_valid  output  1  every column FIFO is non-empty (a full row is poppable)

Behaviour:
- Reset (reset==0 at posedge):
  - All read/write pointers are cleared to 0.
  - out = 0; o_full = 0; o_ready = 1; o_valid = 0.
  - Storage contents are don't-care.
  - Reset mid-operation discards all queued data. The first push after reset release lands in entry 0.
- Per-column FIFO:
  - Read and write pointers are log2(depth)+1 bits wide; the MSB is the wrap bit.
  - Empty: pointers are equal.
  - Full: low bits are equal and MSBs differ.
- Push:
  - wr[i]==1 and column i not full at the start of the cycle: write lane i to mem[wptr], increment wptr.
  - wr[i]==1 and column i full: the write is dropped, including when a pop happens in the same cycle. Fullness is evaluated on pre-edge state.
- Pop:
  - rd==1 and o_valid==1: every column increments its rptr, and out captures the head of every column at that edge. Data is visible on out one cycle after rd.
  - rd==1 and o_valid==0: ignored; out holds; no pointer moves.
  - Without an accepted pop, out holds its last value.
- Simultaneous push and pop on a non-full, non-empty column: both take effect; occupancy is unchanged.
- Push into an empty column is not poppable in the same cycle. o_valid reflects it on the next cycle (no fall-through).
- Flags:
  - All flags are combinational from the pointer registers, i.e. updated the cycle after the causing edge.
  - o_ready == ~o_full.
- Pointers wrap modulo 2*depth with no special handling. Columns may hold different occupancies; skew is bounded only by depth.

Optional Feature:
PSUM_OFIFO_ERR_EN
- Defined:
  - Adds output port o_err [col-1:0], reset 0.
  - Bit i sets sticky on any dropped push to column i (wr[i]==1 while full).
  - Cleared only by reset.
- Undefined:
  - No o_err port; dropped pushes are silent.
  - All other behaviour is identical.

Decomposition:
- Shared package:
  - Constants COL, PSUM_BW, OFIFO_DEPTH.
  - Pointer-width constant OFIFO_PTR_W = clog2(OFIFO_DEPTH)+1.
  - Row typedef (packed array of COL psum_bw lanes).
- Sub-module: psum_fifo_col.
  - Single-lane FIFO with push, pop, full, empty and head data; parameters psum_bw and depth.
  - Instantiated col times by generate.
  - The top handles lockstep pop gating, flag reduction and the out register.

Test Plan:
- Reset then idle: o_ready=1, o_valid=0, o_full=0, out=0; rd=1 has no effect.
- Push 1..4 to all columns (lane i value = 16*k+i), then 4 rd pulses: out shows rows k=1..4 in order, one cycle after each rd; o_valid drops after the 4th pop.
- Skewed columns: wr[0] in cycle 0, wr[1] in cycle 1, ..., wr[7] in cycle 7. o_valid rises only the cycle after wr[7]; pop returns the aligned row.
- Fill column 3 with 16 entries: o_full=1, o_ready=0. A 17th push (0xDEAD) is dropped; with PSUM_OFIFO_ERR_EN, o_err[3]=1. Draining returns entries 1..16 only.
- Steady state at occupancy 5 with simultaneous wr=8'hFF and rd for 40 cycles (pointer wrap): occupancy stays 5, data order is preserved, flags are constant.
- Assert reset with 6 rows queued: next cycle o_valid=0 and out=0; a new row pushed post-reset pops correctly.
